// File: rtl/store_bank_pkg.sv
// store_bank_pkg: shared state type and default sizing for the calculator memory bank
package store_bank_pkg;
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;
endpackage

// File: rtl/store_bank.sv
// store_bank: DEPTH-slot memory with overwrite/accumulate store, registered recall and clear sweep
module store_bank
  import store_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [AW-1:0]    addr,
  input  logic             store,
  input  logic             add_mode,
  input  logic             recall,
  input  logic             clear,
  output logic [WIDTH-1:0] Y,
  output logic             y_valid,
  output logic             slot_valid,
  output logic             ovf,
  output logic             busy
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;
  state_t           state;
  logic [AW-1:0]    idx;
  logic             hit, wr;
  logic [WIDTH-1:0] cur, wdata;
  logic [WIDTH:0]   sum;
  assign hit   = int'(addr) < DEPTH;
  assign wr    = store && hit;
  assign cur   = hit ? mem[addr] : '0;
  assign sum   = {1'b0, cur} + {1'b0, A};
  assign wdata = add_mode ? sum[WIDTH-1:0] : A;
  assign busy  = state == CLEAR;
  // recall is write-first: a same-cycle store to the same slot is forwarded to Y
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      valid      <= '0;
      Y          <= '0;
      y_valid    <= 1'b0;
      slot_valid <= 1'b0;
      ovf        <= 1'b0;
      state      <= IDLE;
      idx        <= '0;
    end else if (busy) begin
      mem[idx]   <= '0;
      valid[idx] <= 1'b0;
      idx        <= idx == LAST ? '0 : idx + 1'b1;
      state      <= idx == LAST ? IDLE : CLEAR;
      y_valid    <= 1'b0;
    end else if (clear) begin
      state      <= CLEAR;
      idx        <= '0;
      y_valid    <= 1'b0;
    end else begin
      if (wr) begin
        mem[addr]   <= wdata;
        valid[addr] <= 1'b1;
        ovf         <= add_mode & sum[WIDTH];
      end
      if (recall) begin
        Y          <= wr ? wdata : cur;
        slot_valid <= hit && (store || valid[addr]);
      end
      y_valid <= recall;
    end
endmodule
